ddr4_cmd_initiator: RTL and testbench
=====================================

// Module: ddr4_cmd_initiator
// PURPOSE
//  Host-side DDR4 command initiator; drives the command/address/DQ pins of the DDR4 device model.
//  Power-up: CKE release, then MR0/MR1 programming. Then serves one host request at a time, closed-page:
//  ACT -> RD/WR -> PRE, with tRCD/CL/CWL/tRP counters. Sits between the system bus and the memory device.
// PARAMETERS
//  T_INIT   8  cycles CKE held low after reset release
//  T_MOD    4  cycles after each MRS before next command
//  T_RCD    3  cycles from ACT to RD/WR
//  T_RP     3  cycles from PRE to next ACT (return to IDLE)
//  CL       5  read latency, RD command to dq sample (5'b range, written to MR0 addr[7:3])
//  CWL      4  write latency, WR command to dq drive (3'b range, written to MR1 addr[10:8])
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous active-low reset
//  req_valid     in   1   host request present
//  req_ready     out  1   request accepted when valid&ready
//  req_we        in   1   1=write, 0=read
//  req_addr      in   32  [31:16] row, [15:6] col, [5:4] bank group, [3:0] bank
//  req_wdata     in   16  write data
//  rsp_valid     out  1   1-cycle pulse: read data valid / write done
//  rsp_rdata     out  16  read data (held until next rsp_valid)
//  ddr4_cke, ddr4_cs_n, ddr4_act_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n  out 1 each  command pins
//  ddr4_addr     out  32  command address
//  ddr4_dm       out  1   1 during ACT/WR of a write (device selects WRITE), 0 otherwise
//  ddr4_odt      out  1   1 during write data cycle
//  ddr4_dq_out   out  16  data to pad;  ddr4_dq_oe out 1 pad drive enable
//  ddr4_dq_in    in   16  data from pad
//  busy          out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state=INIT, counter=0, cke=0, cs_n=act_n=ras_n=cas_n=we_n=1, addr=0,
//   dm=odt=dq_oe=0, dq_out=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=1. Reset mid-op aborts at once.
//  All outputs registered. Commands are 1 cycle; every other cycle is DES (cs_n=1, act_n/ras/cas/we=1).
//  Encoding (cs_n=0): ACT act_n=0; MRS ras,cas,we=000; RD 101; WR 100; PRE 010 (act_n=1 except ACT).
//  FSM:
//   INIT: count T_INIT cycles, then cke=1 -> MRS0.
//   MRS0: issue MRS, addr[12:11]=00, addr[7:3]=CL, addr[2]=0, addr[1:0]=00; wait T_MOD -> MRS1.
//   MRS1: issue MRS, addr[12:11]=01, addr[10:8]=CWL; wait T_MOD -> IDLE.
//   IDLE: req_ready=1 (only state where it is 1). On valid&ready latch we/addr/wdata -> ACT next cycle.
//   ACT: issue ACT, addr=latched addr, dm=we; wait T_RCD-1 DES cycles -> RW.
//   RW: issue RD or WR, addr=latched addr, dm=we. Read: sample dq_in exactly CL cycles after RD.
//    Write: dq_oe=1, odt=1, dq_out=wdata for exactly one cycle, CWL cycles after WR.
//   PRE: entered the cycle after the data cycle; issue PRE, wait T_RP-1 DES -> IDLE.
//  rsp_valid pulses 1 cycle in the PRE issue cycle; rsp_rdata updated same cycle for reads only.
//  Back-to-back: earliest next accept is the first IDLE cycle; ACT-to-ACT spacing per request =
//   1+T_RCD+max(CL,CWL path)+T_RP cycles; no command overlap ever.
//  req_valid low in IDLE: stay IDLE, pins DES. Requests arriving before IDLE are not accepted.
//  Counters sized for max(T_INIT,CL,...) +1 bits; no wrap; params must be >=1.
// TESTING
//  1 Reset release: cke=0 for 8 cycles, MRS addr[12:11]=00 addr[7:3]=5, then MRS addr[12:11]=01 addr[10:8]=4, req_ready=1.
//  2 Write 0x0003_0040 data 0xBEEF: ACT dm=1, WR 3 cycles later, dq_oe/odt=1 with 0xBEEF 4 cycles after WR, PRE, rsp_valid.
//  3 Read same address, bench drives dq_in=0xBEEF 5 cycles after RD: rsp_rdata=0xBEEF, rsp_valid 1 cycle.
//  4 req_valid held high for two reads: second accepted only after T_RP, ACTs separated per timing, no overlap.
//  5 Assert rst during WAIT_CL: next cycle all pins DES, cke=0, dq_oe=0, rsp_valid never pulses, init reruns.
//  6 req_valid during INIT/MRS: req_ready=0, request accepted only in first IDLE cycle.

Source files
------------

// File: rtl/ddr4_cmd_initiator.sv
// Host-side DDR4 command initiator: CKE release and MR0/MR1 programming after reset,
// then one closed-page ACT -> RD/WR -> PRE transaction per accepted host request.
module ddr4_cmd_initiator #(
    parameter int unsigned T_INIT = 8,
    parameter int unsigned T_MOD  = 4,
    parameter int unsigned T_RCD  = 3,
    parameter int unsigned T_RP   = 3,
    parameter int unsigned CL     = 5,
    parameter int unsigned CWL    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        ddr4_cke,
    output logic        ddr4_cs_n,
    output logic        ddr4_act_n,
    output logic        ddr4_ras_n,
    output logic        ddr4_cas_n,
    output logic        ddr4_we_n,
    output logic [31:0] ddr4_addr,
    output logic        ddr4_dm,
    output logic        ddr4_odt,
    output logic [15:0] ddr4_dq_out,
    output logic        ddr4_dq_oe,
    input  logic [15:0] ddr4_dq_in,
    output logic        busy
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned MAX_A  = (T_INIT > T_MOD) ? T_INIT : T_MOD;
    localparam int unsigned MAX_B  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int unsigned MAX_C  = (CL > CWL) ? CL : CWL;
    localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_T  = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned CNT_W  = $clog2(MAX_T + 1) + 1;

    // MR0 carries CAS latency in [7:3]; MR1 (BG/BA=01) carries CWL in [10:8]
    localparam logic [ADDR_W-1:0] MR0_ADDR = {19'd0, 2'b00, 3'b000, 5'(CL), 3'b000};
    localparam logic [ADDR_W-1:0] MR1_ADDR = {19'd0, 2'b01, 3'(CWL), 8'd0};

    typedef enum logic [2:0] {
        ST_INIT, ST_MRS0, ST_MRS1, ST_IDLE, ST_ACT, ST_RW, ST_XFER, ST_PRE
    } state_e;

    typedef enum logic [2:0] {
        CMD_DES, CMD_MRS, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE
    } cmd_e;

    state_e              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                lat_we, lat_we_nxt;
    logic [ADDR_W-1:0]   lat_addr, lat_addr_nxt;
    logic [DATA_W-1:0]   lat_wdata, lat_wdata_nxt;

    cmd_e                cmd;
    logic [ADDR_W-1:0]   cmd_addr;
    logic                req_ready_nxt, busy_nxt, rsp_valid_nxt;
    logic [DATA_W-1:0]   rsp_rdata_nxt;
    logic                cke_nxt, cs_n_nxt, act_n_nxt, ras_n_nxt, cas_n_nxt, we_n_nxt;
    logic                dm_nxt, odt_nxt, dq_oe_nxt;
    logic [DATA_W-1:0]   dq_out_nxt;
    logic [CNT_W-1:0]    data_wait;

    assign data_wait = lat_we ? CNT_W'(CWL - 1) : CNT_W'(CL - 1);

    // State register and registered pin/response outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_INIT;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            ddr4_cke    <= 1'b0;
            ddr4_cs_n   <= 1'b1;
            ddr4_act_n  <= 1'b1;
            ddr4_ras_n  <= 1'b1;
            ddr4_cas_n  <= 1'b1;
            ddr4_we_n   <= 1'b1;
            ddr4_addr   <= '0;
            ddr4_dm     <= 1'b0;
            ddr4_odt    <= 1'b0;
            ddr4_dq_out <= '0;
            ddr4_dq_oe  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            lat_we      <= lat_we_nxt;
            lat_addr    <= lat_addr_nxt;
            lat_wdata   <= lat_wdata_nxt;
            req_ready   <= req_ready_nxt;
            busy        <= busy_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            ddr4_cke    <= cke_nxt;
            ddr4_cs_n   <= cs_n_nxt;
            ddr4_act_n  <= act_n_nxt;
            ddr4_ras_n  <= ras_n_nxt;
            ddr4_cas_n  <= cas_n_nxt;
            ddr4_we_n   <= we_n_nxt;
            ddr4_addr   <= cmd_addr;
            ddr4_dm     <= dm_nxt;
            ddr4_odt    <= odt_nxt;
            ddr4_dq_out <= dq_out_nxt;
            ddr4_dq_oe  <= dq_oe_nxt;
        end
    end

    // Next state; each transition also selects the command shown on the pins next cycle
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + CNT_W'(1);
        lat_we_nxt    = lat_we;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        cmd           = CMD_DES;
        cmd_addr      = '0;
        cke_nxt       = ddr4_cke;
        dm_nxt        = 1'b0;
        odt_nxt       = 1'b0;
        dq_oe_nxt     = 1'b0;
        dq_out_nxt    = '0;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        cs_n_nxt      = 1'b1;
        act_n_nxt     = 1'b1;
        ras_n_nxt     = 1'b1;
        cas_n_nxt     = 1'b1;
        we_n_nxt      = 1'b1;

        case (state)
            ST_INIT: begin
                if (cnt == CNT_W'(T_INIT - 1)) begin
                    state_nxt = ST_MRS0;
                    cnt_nxt   = '0;
                    cke_nxt   = 1'b1;
                    cmd       = CMD_MRS;
                    cmd_addr  = MR0_ADDR;
                end
            end
            ST_MRS0: begin
                if (cnt == CNT_W'(T_MOD - 1)) begin
                    state_nxt = ST_MRS1;
                    cnt_nxt   = '0;
                    cmd       = CMD_MRS;
                    cmd_addr  = MR1_ADDR;
                end
            end
            ST_MRS1: begin
                if (cnt == CNT_W'(T_MOD - 1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                cnt_nxt = '0;
                if (req_valid && req_ready) begin
                    state_nxt     = ST_ACT;
                    lat_we_nxt    = req_we;
                    lat_addr_nxt  = req_addr;
                    lat_wdata_nxt = req_wdata;
                    cmd           = CMD_ACT;
                    cmd_addr      = req_addr;
                    dm_nxt        = req_we;
                end
            end
            ST_ACT: begin
                if (cnt == CNT_W'(T_RCD - 1)) begin
                    state_nxt = ST_RW;
                    cnt_nxt   = '0;
                    cmd       = lat_we ? CMD_WR : CMD_RD;
                    cmd_addr  = lat_addr;
                    dm_nxt    = lat_we;
                end
            end
            ST_RW: begin
                // Wait out CL/CWL; the data cycle is the single ST_XFER cycle
                if (cnt == data_wait) begin
                    state_nxt = ST_XFER;
                    cnt_nxt   = '0;
                    if (lat_we) begin
                        dq_oe_nxt  = 1'b1;
                        odt_nxt    = 1'b1;
                        dq_out_nxt = lat_wdata;
                    end
                end
            end
            ST_XFER: begin
                state_nxt     = ST_PRE;
                cnt_nxt       = '0;
                cmd           = CMD_PRE;
                cmd_addr      = lat_addr;
                rsp_valid_nxt = 1'b1;
                if (!lat_we) begin
                    rsp_rdata_nxt = ddr4_dq_in;
                end
            end
            ST_PRE: begin
                if (cnt == CNT_W'(T_RP - 1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase

        req_ready_nxt = (state_nxt == ST_IDLE);
        busy_nxt      = (state_nxt != ST_IDLE);

        case (cmd)
            CMD_MRS: begin
                cs_n_nxt  = 1'b0;
                ras_n_nxt = 1'b0;
                cas_n_nxt = 1'b0;
                we_n_nxt  = 1'b0;
            end
            CMD_ACT: begin
                cs_n_nxt  = 1'b0;
                act_n_nxt = 1'b0;
            end
            CMD_RD: begin
                cs_n_nxt  = 1'b0;
                cas_n_nxt = 1'b0;
            end
            CMD_WR: begin
                cs_n_nxt  = 1'b0;
                cas_n_nxt = 1'b0;
                we_n_nxt  = 1'b0;
            end
            CMD_PRE: begin
                cs_n_nxt  = 1'b0;
                ras_n_nxt = 1'b0;
                we_n_nxt  = 1'b0;
            end
            default: begin
                cs_n_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ddr4_cmd_initiator.sv
// Scoreboard bench for ddr4_cmd_initiator: a timeline model predicts every command,
// data cycle and response; a monitor pops and compares each one the DUT presents.
module tb_ddr4_cmd_initiator;

    localparam int T_INIT = 8;
    localparam int T_MOD  = 4;
    localparam int T_RCD  = 3;
    localparam int T_RP   = 3;
    localparam int CL     = 5;
    localparam int CWL    = 4;
    localparam int INF    = 32'h3fff_ffff;
    localparam int K_BAD  = 0;
    localparam int K_ACT  = 1;
    localparam int K_MRS  = 2;
    localparam int K_RD   = 3;
    localparam int K_WR   = 4;
    localparam int K_PRE  = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] addr;
        bit          chk_addr;
        logic        dm;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } dat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        ddr4_cke, ddr4_cs_n, ddr4_act_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n;
    logic [31:0] ddr4_addr;
    logic        ddr4_dm, ddr4_odt, ddr4_dq_oe;
    logic [15:0] ddr4_dq_out;
    logic [15:0] ddr4_dq_in = '0;
    logic        busy;

    ddr4_cmd_initiator dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ddr4_cke(ddr4_cke), .ddr4_cs_n(ddr4_cs_n), .ddr4_act_n(ddr4_act_n),
        .ddr4_ras_n(ddr4_ras_n), .ddr4_cas_n(ddr4_cas_n), .ddr4_we_n(ddr4_we_n),
        .ddr4_addr(ddr4_addr), .ddr4_dm(ddr4_dm), .ddr4_odt(ddr4_odt),
        .ddr4_dq_out(ddr4_dq_out), .ddr4_dq_oe(ddr4_dq_oe), .ddr4_dq_in(ddr4_dq_in),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    cmd_t exp_cmd[$];
    dat_t exp_dq[$];
    dat_t exp_rsp[$];
    dat_t drv_q[$];

    // Timeline model state
    int          win_start = INF, win_end = INF, next_start = INF;
    int          cke_from = INF, cke_to = INF;
    int          next_idle = INF;
    logic [15:0] last_rd = '0;
    bit          mon_en = 1'b0;
    bit          rst_prev_low = 1'b1;
    logic [15:0] held_rdata = '0;
    cmd_t        mc;
    dat_t        md;
    logic        exp_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int decode_kind(input logic act_n, input logic ras, input logic cas,
                                       input logic we);
        if (act_n === 1'b0) return K_ACT;
        case ({ras, cas, we})
            3'b000:  return K_MRS;
            3'b101:  return K_RD;
            3'b100:  return K_WR;
            3'b010:  return K_PRE;
            default: return K_BAD;
        endcase
    endfunction

    // Monitor: samples mid-cycle, pops expectations for every event the DUT presents
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_prev_low) begin
                held_rdata = '0;
                chk("reset addr", ddr4_addr, 32'd0);
                chk("reset dq_out", 32'(ddr4_dq_out), 32'd0);
                chk("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
            end
            exp_rdy = (cyc >= win_start && cyc <= win_end) || (cyc >= next_start);
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(!exp_rdy));
            chk("cke", 32'(ddr4_cke), 32'(cyc >= cke_from && cyc < cke_to));

            if (ddr4_cs_n === 1'b0) begin
                if (exp_cmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd: unexpected command kind %0d at cycle %0d, none required",
                             decode_kind(ddr4_act_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n), cyc);
                end else begin
                    mc = exp_cmd.pop_front();
                    chk("cmd cycle", 32'(cyc), 32'(mc.cyc));
                    chk("cmd kind", 32'(decode_kind(ddr4_act_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n)),
                        32'(mc.kind));
                    if (mc.chk_addr) chk("cmd addr", ddr4_addr, mc.addr);
                    chk("cmd dm", 32'(ddr4_dm), 32'(mc.dm));
                end
            end else begin
                chk("des pins", 32'({ddr4_cs_n, ddr4_act_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n, ddr4_dm}),
                    32'(6'b111110));
            end

            if (ddr4_dq_oe === 1'b1) begin
                if (exp_dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dq: unexpected dq_oe at cycle %0d, none required", cyc);
                end else begin
                    md = exp_dq.pop_front();
                    chk("dq cycle", 32'(cyc), 32'(md.cyc));
                    chk("dq_out", 32'(ddr4_dq_out), 32'(md.data));
                    chk("odt in data cycle", 32'(ddr4_odt), 32'd1);
                end
            end else begin
                chk("dq_oe/odt idle", 32'({ddr4_dq_oe, ddr4_odt}), 32'd0);
            end

            if (rsp_valid === 1'b1) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp: unexpected rsp_valid at cycle %0d, none required", cyc);
                end else begin
                    md = exp_rsp.pop_front();
                    chk("rsp cycle", 32'(cyc), 32'(md.cyc));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(md.data));
                    held_rdata = md.data;
                end
            end else begin
                chk("rsp_valid low", 32'(rsp_valid), 32'd0);
                chk("rsp_rdata held", 32'(rsp_rdata), 32'(held_rdata));
            end
        end
        rst_prev_low = (rst == 1'b0);
    end

    // Pad model: scheduled read data on its cycle, random junk otherwise
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (drv_q.size() > 0 && drv_q[0].cyc == cyc) begin
                ddr4_dq_in = drv_q[0].data;
                void'(drv_q.pop_front());
            end else begin
                ddr4_dq_in = 16'($urandom);
            end
        end
    end

    // Release reset now and predict the power-up sequence
    task automatic init_seq();
        rst        = 1'b1;
        cke_from   = cyc + T_INIT;
        cke_to     = INF;
        exp_cmd.push_back('{cyc + T_INIT, K_MRS, 32'(CL) << 3, 1'b1, 1'b0});
        exp_cmd.push_back('{cyc + T_INIT + T_MOD, K_MRS, (32'd1 << 11) | (32'(CWL) << 8), 1'b1, 1'b0});
        next_idle  = cyc + T_INIT + 2 * T_MOD;
        win_start  = next_idle;
        win_end    = INF;
        next_start = INF;
    endtask

    // Raise a request now; predict its full timeline; return in its ACT cycle
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [15:0] wd,
                          input logic [15:0] rd, output int w_cyc);
        int a, w, p, lat;
        a   = (cyc > next_idle) ? cyc : next_idle;
        lat = we ? CWL : CL;
        w   = a + 1 + T_RCD;
        p   = w + lat + 1;
        win_end    = a;
        next_start = p + T_RP;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        exp_cmd.push_back('{a + 1, K_ACT, addr, 1'b1, we});
        exp_cmd.push_back('{w, we ? K_WR : K_RD, addr, 1'b1, we});
        if (we) begin
            exp_dq.push_back('{w + lat, wd});
        end else begin
            drv_q.push_back('{w + lat, rd});
            last_rd = rd;
        end
        exp_cmd.push_back('{p, K_PRE, 32'd0, 1'b0, 1'b0});
        exp_rsp.push_back('{p, last_rd});
        next_idle = p + T_RP;
        w_cyc     = w;
        while (cyc <= a) begin
            @(posedge clk);
            #1;
        end
        req_valid  = 1'b0;
        req_addr   = 32'($urandom);
        win_start  = next_start;
        win_end    = INF;
        next_start = INF;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          w;
    int          gap;
    logic        r_we;
    logic [31:0] r_addr;
    logic [15:0] r_wd, r_rd;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle_cycles(2);

        // Power-up, with a write already pending during INIT/MRS
        init_seq();
        do_req(1'b1, 32'h0003_0040, 16'hBEEF, 16'h0000, w);
        // Read back the same address, valid held across both reads that follow
        do_req(1'b0, 32'h0003_0040, 16'h0000, 16'hBEEF, w);
        do_req(1'b0, 32'h1234_5678, 16'h0000, 16'h5A5A, w);

        for (int i = 0; i < 24; i++) begin
            gap    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 0;
            r_we   = 1'($urandom);
            r_addr = $urandom;
            r_wd   = 16'($urandom);
            r_rd   = 16'($urandom);
            idle_cycles(gap);
            do_req(r_we, r_addr, r_wd, r_rd, w);
        end

        // Abort a read while it waits for CL
        idle_cycles(4);
        do_req(1'b0, 32'hCAFE_0010, 16'h0000, 16'h1357, w);
        while (cyc < w + 2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_cmd.delete();
        exp_dq.delete();
        exp_rsp.delete();
        drv_q.delete();
        last_rd    = '0;
        cke_to     = cyc + 1;
        win_start  = INF;
        win_end    = INF;
        next_start = INF;
        next_idle  = INF;
        idle_cycles(3);

        init_seq();
        do_req(1'b0, 32'h0003_0040, 16'h0000, 16'h2468, w);
        do_req(1'b1, 32'h00FF_FFC0, 16'h8001, 16'h0000, w);

        for (int i = 0; i < 200 && (exp_cmd.size() + exp_dq.size() + exp_rsp.size()) > 0; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if ((exp_cmd.size() + exp_dq.size() + exp_rsp.size()) != 0) begin
            errors++;
            $display("FAIL drain: %0d events outstanding, required 0",
                     exp_cmd.size() + exp_dq.size() + exp_rsp.size());
        end
        idle_cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
